bus_master_port: RTL and testbench

- Initiator end of the shared system bus (addr_bus / data_bus / rd_bus / wr_bus / data_mask_bus / fc_bus) that every memory-mapped device responder sits on.
- Accepts single load/store requests from a core-side port and runs one bus transaction per request.
- Handles size-to-mask encoding and right-aligned data lanes, load sign/zero extension, misalignment rejection and a completion timeout.
- Single master on the bus; no arbitration.

---
 rtl/bus_master_port.sv | 164 ++++++++++++++++
 tb/tb_bus_master_port.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_port.sv
// Initiator side of the shared system bus: runs one load or store transaction per core request.
// Produces the byte mask, extends load data, rejects misaligned requests and gives up after a timeout.
module bus_master_port #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        load_signed,
  output logic        rdy,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [31:0] addr_bus,
  inout  wire  [31:0] data_bus,
  output logic        rd_bus,
  output logic        wr_bus,
  output logic [3:0]  data_mask_bus,
  input  logic        fc_bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] READ    = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [31:0] wdata_q;
  logic        signed_q;
  logic        drive_q;
  logic [15:0] wait_count;

  logic        illegal;
  logic [3:0]  req_mask;
  logic [31:0] load_value;
  logic        complete;
  logic        expired;

  assign busy     = (state != IDLE);
  assign data_bus = drive_q ? wdata_q : {32{1'bz}};

  // An undriven or unknown fc_bus must never look like a completion.
  assign complete = (fc_bus == 1'b1);
  assign expired  = (wait_count == LAST_COUNT);

  always_comb begin
    illegal  = 1'b0;
    req_mask = 4'b0000;
    case (size)
      2'd0: req_mask = 4'b0001;
      2'd1: begin
        req_mask = 4'b0011;
        illegal  = addr[0];
      end
      2'd2: begin
        req_mask = 4'b1111;
        illegal  = (addr[1:0] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

  // Load data arrives right-aligned; the latched mask tells how many lanes are meaningful.
  always_comb begin
    load_value = data_bus;
    if (data_mask_bus == 4'b0001)
      load_value = {{24{signed_q & data_bus[7]}}, data_bus[7:0]};
    else if (data_mask_bus == 4'b0011)
      load_value = {{16{signed_q & data_bus[15]}}, data_bus[15:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rdy           <= 1'b0;
      err           <= 1'b0;
      rdata         <= 32'd0;
      rd_bus        <= 1'b0;
      wr_bus        <= 1'b0;
      addr_bus      <= 32'd0;
      data_mask_bus <= 4'b0000;
      wdata_q       <= 32'd0;
      signed_q      <= 1'b0;
      drive_q       <= 1'b0;
      wait_count    <= 16'd0;
    end else begin
      rdy <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (illegal) begin
              rdy <= 1'b1;
              err <= 1'b1;
            end else begin
              addr_bus      <= addr;
              data_mask_bus <= req_mask;
              wdata_q       <= wdata;
              signed_q      <= load_signed;
              wait_count    <= 16'd0;
              if (we) begin
                state   <= WRITE;
                wr_bus  <= 1'b1;
                drive_q <= 1'b1;
              end else begin
                state  <= READ;
                rd_bus <= 1'b1;
              end
            end
          end
        end
        READ: begin
          if (complete || expired) begin
            if (complete)
              rdata <= load_value;
            err           <= ~complete;
            rdy           <= 1'b1;
            rd_bus        <= 1'b0;
            addr_bus      <= 32'd0;
            data_mask_bus <= 4'b0000;
            wait_count    <= 16'd0;
            state         <= IDLE;
          end else begin
            wait_count <= wait_count + 16'd1;
          end
        end
        WRITE: begin
          if (complete) begin
            // Address and mask stay up through RELEASE so the responder sees a clean write drop.
            wr_bus     <= 1'b0;
            drive_q    <= 1'b0;
            wait_count <= 16'd0;
            state      <= RELEASE;
          end else if (expired) begin
            wr_bus        <= 1'b0;
            drive_q       <= 1'b0;
            addr_bus      <= 32'd0;
            data_mask_bus <= 4'b0000;
            wait_count    <= 16'd0;
            rdy           <= 1'b1;
            err           <= 1'b1;
            state         <= IDLE;
          end else begin
            wait_count <= wait_count + 16'd1;
          end
        end
        RELEASE: begin
          addr_bus      <= 32'd0;
          data_mask_bus <= 4'b0000;
          rdy           <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Randomized bench for bus_master_port: a responder with programmable completion delay plus
// a transaction-level model predicting latency, error, strobe lengths and load results.
`timescale 1ns/1ps
module tb_bus_master_port;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        load_signed;
  logic        rdy;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  logic [31:0] addr_bus;
  wire  [31:0] data_bus;
  logic        rd_bus;
  logic        wr_bus;
  logic [3:0]  data_mask_bus;
  wire         fc_bus;

  logic        respond;
  int          fcDelay;
  logic [31:0] readWord;
  int          strobeCnt;
  logic [31:0] rdataModel;
  int          checksDone;
  int          checksFailed;

  bus_master_port #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .load_signed(load_signed), .rdy(rdy), .rdata(rdata), .err(err),
    .busy(busy), .addr_bus(addr_bus), .data_bus(data_bus), .rd_bus(rd_bus),
    .wr_bus(wr_bus), .data_mask_bus(data_mask_bus), .fc_bus(fc_bus)
  );

  always #5 clk = ~clk;

  // Responder: completes combinationally once the strobe has been up for fcDelay cycles.
  assign fc_bus   = (respond && (rd_bus || wr_bus) && strobeCnt >= fcDelay) ? 1'b1 : 1'bz;
  assign data_bus = (respond && rd_bus) ? readWord : {32{1'bz}};

  always @(posedge clk or posedge rst) begin
    if (rst)
      strobeCnt <= 0;
    else if (rd_bus || wr_bus)
      strobeCnt <= strobeCnt + 1;
    else
      strobeCnt <= 0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checksDone++;
    if (got !== exp) begin
      checksFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expLoad(input logic [31:0] w, input logic [1:0] sz, input bit sgn);
    longint span;
    longint v;
    if (sz == 2'd2) return w;
    span = (sz == 2'd0) ? 256 : 65536;
    v = longint'(w) % span;
    if (sgn && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // Starts at a negedge and returns at a negedge; with chain set it returns in the rdy cycle.
  task automatic applyStimulus(input bit isWe, input logic [31:0] a, input logic [31:0] wd,
                               input logic [1:0] sz, input bit sgn, input int delay,
                               input bit resp, input logic [31:0] rw, input bit chain);
    bit          illegal;
    bit          completes;
    int          expLat;
    int          expStrobe;
    bit          expErr;
    int          rdSeen = 0;
    int          wrSeen = 0;
    int          busySeen = 0;
    int          rdyIdx = -1;
    bit          captured = 0;
    logic [31:0] firstAddr = '0;
    logic [31:0] firstData = '0;
    logic [3:0]  firstMask = '0;
    logic        errSeen = 1'b0;
    logic [31:0] rdataSeen = '0;

    illegal   = (sz == 2'd3) || ((a % (32'd1 << sz)) != 0);
    completes = resp && (delay < T);
    if (illegal) begin
      expLat = 1; expStrobe = 0; expErr = 1;
    end else if (completes) begin
      expLat = isWe ? delay + 3 : delay + 2; expStrobe = delay + 1; expErr = 0;
    end else begin
      expLat = T + 1; expStrobe = T; expErr = 1;
    end

    respond = resp; fcDelay = delay; readWord = rw;
    we = isWe; addr = a; wdata = wd; size = sz; load_signed = sgn; req = 1'b1;

    for (int k = 1; k <= T + 10 && rdyIdx < 0; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (rd_bus) rdSeen++;
      if (wr_bus) wrSeen++;
      if (busy) busySeen++;
      if ((rd_bus || wr_bus) && !captured) begin
        captured = 1; firstAddr = addr_bus; firstMask = data_mask_bus; firstData = data_bus;
      end
      if (rdy) begin
        rdyIdx = k; errSeen = err; rdataSeen = rdata;
      end else if (!illegal && k < expLat && $urandom_range(0, 2) == 0) begin
        req = 1'b1; we = 1'($urandom); addr = $urandom; wdata = $urandom;
        size = 2'($urandom); load_signed = 1'($urandom);
      end
    end

    if (!isWe && !illegal && completes) rdataModel = expLoad(rw, sz, sgn);

    checkOutput("latency", rdyIdx, expLat);
    checkOutput("err", errSeen, expErr);
    checkOutput("rd_cycles", rdSeen, (isWe || illegal) ? 0 : expStrobe);
    checkOutput("wr_cycles", wrSeen, (isWe && !illegal) ? expStrobe : 0);
    checkOutput("busy_cycles", busySeen, expLat - 1);
    checkOutput("rdata", rdataSeen, rdataModel);
    if (!illegal) begin
      checkOutput("addr_bus", firstAddr, a);
      checkOutput("mask", firstMask, 32'((1 << (1 << sz)) - 1));
      if (isWe) checkOutput("store_data", firstData, wd);
    end
    if (!chain) begin
      @(negedge clk);
      checkOutput("idle_rdy", rdy, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_addr", addr_bus, 0);
      checkOutput("idle_mask", data_mask_bus, 0);
      checkOutput("idle_strobes", {rd_bus, wr_bus}, 0);
    end
  endtask

  initial begin
    int rdyAfterReset;
    checksDone = 0; checksFailed = 0; rdataModel = 32'd0;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; size = '0; load_signed = 1'b0;
    respond = 1'b0; fcDelay = 0; readWord = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_rdy", rdy, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_rdata", rdata, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_strobes", {rd_bus, wr_bus}, 0);
    checkOutput("reset_addr", addr_bus, 0);
    checkOutput("reset_mask", data_mask_bus, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed transactions");
    applyStimulus(0, 32'h0000_1004, '0, 2'd2, 0, 0, 1, 32'hDEAD_BEEF, 0);
    applyStimulus(0, 32'h0000_2003, '0, 2'd0, 1, 0, 1, 32'h0000_0080, 0);
    applyStimulus(0, 32'h0000_2003, '0, 2'd0, 0, 0, 1, 32'h0000_0080, 0);
    applyStimulus(0, 32'h0000_3002, '0, 2'd1, 1, 2, 1, 32'h5555_9001, 0);
    applyStimulus(1, 32'h0000_4002, 32'h1234_ABCD, 2'd1, 0, 1, 1, '0, 0);
    applyStimulus(0, 32'h0000_5002, '0, 2'd2, 0, 0, 1, 32'hFFFF_FFFF, 0);
    applyStimulus(1, 32'h0000_5001, 32'hCAFE_F00D, 2'd1, 0, 0, 1, '0, 0);
    applyStimulus(0, 32'h0000_5000, '0, 2'd3, 0, 0, 1, 32'h1111_1111, 0);
    applyStimulus(0, 32'h0000_6000, '0, 2'd2, 0, 0, 0, 32'h2222_2222, 0);
    applyStimulus(1, 32'h0000_6004, 32'h0BAD_C0DE, 2'd2, 0, 0, 0, '0, 0);
    applyStimulus(0, 32'h0000_7008, '0, 2'd2, 0, T - 1, 1, 32'h7654_3210, 0);
    applyStimulus(0, 32'h0000_700C, '0, 2'd2, 0, T, 1, 32'h0123_4567, 0);
    applyStimulus(1, 32'h0000_8000, 32'hA5A5_5A5A, 2'd2, 0, 0, 1, '0, 1);
    applyStimulus(0, 32'h0000_8000, '0, 2'd1, 0, 0, 1, 32'h0000_F00F, 0);

    $display("[TB] reset during write");
    respond = 1'b0; we = 1'b1; addr = 32'h0000_9000; wdata = 32'h1357_9BDF; size = 2'd2; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    checkOutput("wr_before_reset", wr_bus, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("wr_after_reset", wr_bus, 0);
    checkOutput("busy_after_reset", busy, 0);
    checkOutput("addr_after_reset", addr_bus, 0);
    @(negedge clk);
    rst = 1'b0;
    rdataModel = 32'd0;
    rdyAfterReset = 0;
    repeat (3) begin
      @(negedge clk);
      if (rdy) rdyAfterReset++;
    end
    checkOutput("rdy_after_reset", rdyAfterReset, 0);
    applyStimulus(0, 32'h0000_9000, '0, 2'd2, 0, 1, 1, 32'h2468_ACE0, 0);

    $display("[TB] random transactions");
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      applyStimulus(1'($urandom), a, $urandom, sz, 1'($urandom), $urandom_range(0, 9),
                    $urandom_range(0, 9) != 0, $urandom, (i != 79) && ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checksDone, checksFailed);
    $finish;
  end

endmodule
